// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: parses A5-framed register commands from the JTAG UART
// bridge, runs one 32-bit read or write on a strobe/ack bus and returns a
// 5A-framed status/data response through the bridge's to-host path.
module uart_cmd_engine #(
    parameter int ADDR_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_din,
    input  logic                  rx_vld,
    output logic [7:0]            tx_dout,
    output logic                  tx_vld,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [31:0]           reg_rdata,
    input  logic                  reg_ack,
    output logic [7:0]            drop_cnt
);

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    localparam logic [7:0]  LP_SOF     = 8'hA5;
    localparam logic [7:0]  LP_RSOF    = 8'h5A;
    localparam logic [7:0]  LP_CMD_WR  = 8'h01;
    localparam logic [7:0]  LP_CMD_RD  = 8'h02;
    localparam logic [7:0]  LP_ST_OK   = 8'h00;
    localparam logic [7:0]  LP_ST_CHK  = 8'h01;
    localparam logic [7:0]  LP_ST_CMD  = 8'h02;
    localparam logic [7:0]  LP_ST_TMO  = 8'h03;
    localparam logic [15:0] LP_TMO     = 16'(ACK_TIMEOUT);

    logic [2:0]            r_state;
    logic [7:0]            r_cmd;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]           r_pdata;
    logic [7:0]            r_xor;
    logic [1:0]            r_bcnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_wr;
    logic                  r_rd;
    logic [7:0]            r_status;
    logic [31:0]           r_rdata;
    logic                  r_has_data;
    logic [15:0]           r_tcnt;
    logic [2:0]            r_idx;
    logic [7:0]            r_drop;

    logic                  w_tx_vld;
    logic [7:0]            w_rchk;
    logic [2:0]            w_last_idx;
    logic [7:0]            w_tx_byte;
    logic                  w_cmd_ok;

    // r_rdata is zero unless a read succeeded, so RCHK can always fold it in
    assign w_rchk     = r_status ^ r_rdata[31:24] ^ r_rdata[23:16] ^ r_rdata[15:8] ^ r_rdata[7:0];
    assign w_last_idx = r_has_data ? 3'd6 : 3'd2;
    assign w_tx_vld   = (r_state == S_RESP) && !tx_busy;
    assign w_cmd_ok   = (r_cmd == LP_CMD_WR) || (r_cmd == LP_CMD_RD);

    // Select the response byte addressed by the emission index
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_idx)
            3'd0:    w_tx_byte = LP_RSOF;
            3'd1:    w_tx_byte = r_status;
            3'd2:    w_tx_byte = r_has_data ? r_rdata[31:24] : w_rchk;
            3'd3:    w_tx_byte = r_rdata[23:16];
            3'd4:    w_tx_byte = r_rdata[15:8];
            3'd5:    w_tx_byte = r_rdata[7:0];
            default: w_tx_byte = w_rchk;
        endcase
    end

    // Frame parser, bus transaction and response sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HUNT;
            r_cmd      <= '0;
            r_paddr    <= '0;
            r_pdata    <= '0;
            r_xor      <= '0;
            r_bcnt     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_status   <= '0;
            r_rdata    <= '0;
            r_has_data <= 1'b0;
            r_tcnt     <= '0;
            r_idx      <= '0;
        end else begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (rx_vld && rx_din == LP_SOF) begin
                        r_xor   <= '0;
                        r_bcnt  <= '0;
                        r_pdata <= '0;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (rx_vld) begin
                        r_cmd   <= rx_din;
                        r_xor   <= r_xor ^ rx_din;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_vld) begin
                        r_paddr <= rx_din[ADDR_WIDTH-1:0];
                        r_xor   <= r_xor ^ rx_din;
                        r_state <= (r_cmd == LP_CMD_WR) ? S_DATA : S_CHK;
                    end
                end
                S_DATA: begin
                    if (rx_vld) begin
                        r_pdata <= {r_pdata[23:0], rx_din};
                        r_xor   <= r_xor ^ rx_din;
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3)
                            r_state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_vld) begin
                        r_addr     <= r_paddr;
                        r_wdata    <= r_pdata;
                        r_rdata    <= '0;
                        r_has_data <= 1'b0;
                        r_idx      <= '0;
                        r_tcnt     <= '0;
                        if (rx_din != r_xor) begin
                            r_status <= LP_ST_CHK;
                            r_state  <= S_RESP;
                        end else if (!w_cmd_ok) begin
                            r_status <= LP_ST_CMD;
                            r_state  <= S_RESP;
                        end else begin
                            r_wr    <= (r_cmd == LP_CMD_WR);
                            r_rd    <= (r_cmd == LP_CMD_RD);
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // r_tcnt==0 marks the strobe cycle, where an ack is ignored
                    if (r_tcnt == 16'd0) begin
                        r_tcnt <= 16'd1;
                    end else if (reg_ack) begin
                        r_status <= LP_ST_OK;
                        if (r_cmd == LP_CMD_RD) begin
                            r_rdata    <= reg_rdata;
                            r_has_data <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else if (r_tcnt == LP_TMO) begin
                        r_status <= LP_ST_TMO;
                        r_state  <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (w_tx_vld) begin
                        if (r_idx == w_last_idx) begin
                            r_idx   <= '0;
                            r_state <= S_HUNT;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    // Count bytes that arrive while a transaction or response is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_drop <= '0;
        else if (rx_vld && (r_state == S_EXEC || r_state == S_RESP) && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
    end

    assign tx_vld    = w_tx_vld;
    assign tx_dout   = (r_state == S_RESP) ? w_tx_byte : 8'h00;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign drop_cnt  = r_drop;

endmodule
